// File: rtl/lsu_mem_if_if.sv
// Bundle of the execute-stage request/response handshake and the
// data-memory controller bus seen by the load/store unit.
interface lsu_mem_if_if;
    // Execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Completion back to the core
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    // Memory controller side
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_wflag;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // Load/store unit view
    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_wdata, mem_wflag, mem_we, mem_re,
        input  mem_rdata, mem_ready
    );

    // Environment view (execute stage plus memory controller)
    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_wdata, mem_wflag, mem_we, mem_re,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit memory initiator: accepts one load/store, strobes the
// data-memory controller until mem_ready or timeout, then returns an
// extended load result, a store completion or an error response.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_mem_if_if.master bus
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [2:0]    op_funct3;
    logic          req_bad;

    // Load-data extension from the low lanes of the returned word
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b100:  r = {24'b0, d[7:0]};
            3'b101:  r = {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Classify the incoming request as illegal or misaligned
    always_comb begin
        req_bad = 1'b0;
        if (bus.req_store) begin
            if (!(bus.req_funct3 inside {3'b000, 3'b001, 3'b010}))
                req_bad = 1'b1;
        end else begin
            if (!(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                req_bad = 1'b1;
        end
        if (ALIGN_CHECK) begin
            if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
                req_bad = 1'b1;
            if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
                req_bad = 1'b1;
        end
    end

    // Request/access/response sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            count          <= '0;
            op_funct3      <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_wflag  <= 3'b010;
            bus.mem_we     <= 1'b0;
            bus.mem_re     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        if (req_bad) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                            state          <= RESP;
                        end else begin
                            bus.mem_addr  <= bus.req_addr;
                            bus.mem_wdata <= bus.req_wdata;
                            op_funct3     <= bus.req_funct3;
                            if (bus.req_store) begin
                                bus.mem_wflag <= bus.req_funct3;
                                bus.mem_we    <= 1'b1;
                            end else begin
                                bus.mem_wflag <= 3'b010;
                                bus.mem_re    <= 1'b1;
                            end
                            count <= '0;
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // mem_ready wins over an expiring timeout in the same cycle
                    if (bus.mem_ready) begin
                        bus.mem_we     <= 1'b0;
                        bus.mem_re     <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= bus.mem_we ? '0 : extend(op_funct3, bus.mem_rdata);
                        state          <= RESP;
                    end else if (count == LAST_COUNT) begin
                        bus.mem_we     <= 1'b0;
                        bus.mem_re     <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                        state          <= RESP;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    bus.mem_we     <= 1'b0;
                    bus.mem_re     <= 1'b0;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: directed requests push expected
// responses; a negedge monitor pops and compares on every resp_valid.
module tb_lsu_mem_if;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lsu_mem_if_if bus();

    lsu_mem_if #(.TIMEOUT_CYCLES(16), .ALIGN_CHECK(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Driver and controller-model registers
    logic        drv_valid = 1'b0;
    logic        drv_store = 1'b0;
    logic [2:0]  drv_funct3 = 3'b000;
    logic [31:0] drv_addr = '0;
    logic [31:0] drv_wdata = '0;
    logic        ctl_ready = 1'b0;
    logic [31:0] ctl_rdata = '0;
    logic        ctrl_en = 1'b1;

    assign bus.req_valid  = drv_valid;
    assign bus.req_store  = drv_store;
    assign bus.req_funct3 = drv_funct3;
    assign bus.req_addr   = drv_addr;
    assign bus.req_wdata  = drv_wdata;
    assign bus.mem_ready  = ctl_ready;
    assign bus.mem_rdata  = ctl_rdata;

    int pass_count = 0;
    int total_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Byte-addressed memory behind the controller model
    logic [7:0] mem [int unsigned];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // Controller: answers on the falling edge after a strobe is seen
    always @(negedge clk) begin
        if (ctrl_en && (bus.mem_we || bus.mem_re) && !ctl_ready) begin
            ctl_ready <= 1'b1;
            if (bus.mem_we) begin
                mem[bus.mem_addr] = bus.mem_wdata[7:0];
                if (bus.mem_wflag != 3'b000) mem[bus.mem_addr + 1] = bus.mem_wdata[15:8];
                if (bus.mem_wflag == 3'b010) begin
                    mem[bus.mem_addr + 2] = bus.mem_wdata[23:16];
                    mem[bus.mem_addr + 3] = bus.mem_wdata[31:24];
                end
            end else begin
                ctl_rdata <= {rd_byte(bus.mem_addr + 3), rd_byte(bus.mem_addr + 2),
                              rd_byte(bus.mem_addr + 1), rd_byte(bus.mem_addr)};
            end
        end else begin
            ctl_ready <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and observation state
    logic [32:0] exp_q [$];
    int resp_count = 0;
    int last_resp_cyc = 0;
    logic ready_at_resp = 1'b0;
    int accept_log [$];
    int we_pulses = 0, re_pulses = 0;
    int we_run = 0, re_run = 0;
    int last_we_len = 0, last_re_len = 0;
    int last_re_cyc = 0;
    logic [2:0] wflag_at_we = 3'b111;
    logic prev_we = 1'b0, prev_re = 1'b0;
    logic both_high = 1'b0;
    logic overlap_bad = 1'b0;

    // Monitor: responses, accepts and strobe shapes, sampled mid-cycle
    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.resp_valid) begin
            resp_count++;
            last_resp_cyc = cyc;
            ready_at_resp = bus.req_ready;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", {31'b0, bus.resp_err}, {31'b0, e[32]});
                check("resp_rdata", bus.resp_rdata, e[31:0]);
            end
        end
        if (bus.req_valid && bus.req_ready) accept_log.push_back(cyc + 1);
        if (bus.mem_we && bus.mem_re) both_high = 1'b1;
        if (bus.mem_we && !prev_we) begin
            we_pulses++;
            we_run = 0;
            wflag_at_we = bus.mem_wflag;
            if (bus.mem_ready) overlap_bad = 1'b1;
        end
        if (bus.mem_re && !prev_re) begin
            re_pulses++;
            re_run = 0;
            if (bus.mem_ready) overlap_bad = 1'b1;
        end
        if (bus.mem_we) we_run++;
        if (bus.mem_re) begin
            re_run++;
            last_re_cyc = cyc;
        end
        if (!bus.mem_we && prev_we) last_we_len = we_run;
        if (!bus.mem_re && prev_re) last_re_len = re_run;
        prev_we = bus.mem_we;
        prev_re = bus.mem_re;
    end

    // Present one request; returns just after the accepting edge
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit push, input logic err,
                        input logic [31:0] rdata, input bit keep);
        int n;
        if (push) exp_q.push_back({err, rdata});
        drv_store = st; drv_funct3 = f3; drv_addr = a; drv_wdata = wd;
        drv_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) drv_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target, input int bound);
        int n;
        n = 0;
        while (resp_count < target) begin
            @(posedge clk);
            n++;
            if (n > bound) begin
                check("resp_wait_timeout", resp_count, target);
                break;
            end
        end
        #1;
    endtask

    initial begin
        int we0, re0, rc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_strobes", {30'b0, bus.mem_we, bus.mem_re}, 32'd0);
        check("rst_mem_wflag", {29'b0, bus.mem_wflag}, 32'd2);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SW then LW of the same word
        send(1'b1, 3'b010, 32'h2000, 32'hDEADBEEF, 1, 1'b0, 32'h0, 0);
        wait_resp(1, 20);
        check("sw_we_len", last_we_len, 32'd1);
        check("sw_wflag", {29'b0, wflag_at_we}, 32'd2);
        check("sw_resp_latency", last_resp_cyc, accept_log[accept_log.size()-1] + 1);
        send(1'b0, 3'b010, 32'h2000, 32'h0, 1, 1'b0, 32'hDEADBEEF, 0);
        wait_resp(2, 20);
        check("lw_re_len", last_re_len, 32'd1);

        // SB then byte/half loads with sign and zero extension
        send(1'b1, 3'b000, 32'h2001, 32'h00000080, 1, 1'b0, 32'h0, 0);
        wait_resp(3, 20);
        check("sb_wflag", {29'b0, wflag_at_we}, 32'd0);
        send(1'b0, 3'b000, 32'h2001, 32'h0, 1, 1'b0, 32'hFFFFFF80, 0);
        wait_resp(4, 20);
        send(1'b0, 3'b100, 32'h2001, 32'h0, 1, 1'b0, 32'h00000080, 0);
        wait_resp(5, 20);
        send(1'b0, 3'b001, 32'h2000, 32'h0, 1, 1'b0, 32'hFFFF80EF, 0);
        wait_resp(6, 20);
        send(1'b0, 3'b101, 32'h2000, 32'h0, 1, 1'b0, 32'h000080EF, 0);
        wait_resp(7, 20);

        // Misaligned and illegal requests: error, no strobe
        we0 = we_pulses; re0 = re_pulses;
        send(1'b0, 3'b010, 32'h2002, 32'h0, 1, 1'b1, 32'h0, 0);
        wait_resp(8, 20);
        send(1'b1, 3'b001, 32'h2001, 32'h1234, 1, 1'b1, 32'h0, 0);
        wait_resp(9, 20);
        send(1'b0, 3'b011, 32'h2000, 32'h0, 1, 1'b1, 32'h0, 0);
        wait_resp(10, 20);
        send(1'b1, 3'b100, 32'h2000, 32'h0, 1, 1'b1, 32'h0, 0);
        wait_resp(11, 20);
        check("err_no_re", re_pulses, re0);
        check("err_no_we", we_pulses, we0);

        // Unresponsive controller: timeout after 16 strobe cycles
        ctrl_en = 1'b0;
        send(1'b0, 3'b010, 32'h2004, 32'h0, 1, 1'b1, 32'h0, 0);
        wait_resp(12, 40);
        check("to_re_len", last_re_len, 32'd16);
        check("to_resp_cycle", last_resp_cyc, last_re_cyc + 1);
        check("to_ready_at_resp", {31'b0, ready_at_resp}, 32'd0);
        check("to_ready_after", {31'b0, bus.req_ready}, 32'd1);
        ctrl_en = 1'b1;

        // Back-to-back loads with req_valid held high
        accept_log.delete();
        send(1'b0, 3'b010, 32'h2000, 32'h0, 1, 1'b0, 32'hDEAD80EF, 1);
        send(1'b0, 3'b100, 32'h2001, 32'h0, 1, 1'b0, 32'h00000080, 1);
        send(1'b0, 3'b101, 32'h2000, 32'h0, 1, 1'b0, 32'h000080EF, 1);
        send(1'b0, 3'b000, 32'h2003, 32'h0, 1, 1'b0, 32'hFFFFFFDE, 0);
        wait_resp(16, 30);
        check("b2b_accepts", accept_log.size(), 32'd4);
        if (accept_log.size() == 4) begin
            for (int unsigned i = 1; i < 4; i++)
                check("b2b_spacing", accept_log[i] - accept_log[i-1], 32'd3);
        end

        // Reset in the middle of a store access
        ctrl_en = 1'b0;
        send(1'b1, 3'b010, 32'h3000, 32'h11223344, 0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("pre_rst_we", {31'b0, bus.mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_we", {31'b0, bus.mem_we}, 32'd0);
        rc = resp_count;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ctrl_en = 1'b1;
        check("rst_ready_after", {31'b0, bus.req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_resp", resp_count, rc);
        send(1'b0, 3'b010, 32'h2000, 32'h0, 1, 1'b0, 32'hDEAD80EF, 0);
        wait_resp(rc + 1, 20);

        repeat (2) @(posedge clk);
        check("strobes_exclusive", {31'b0, both_high}, 32'd0);
        check("no_strobe_over_ready", {31'b0, overlap_bad}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Core-side initiator for the data-memory request interface.
- Accepts one load/store from the execute stage and drives mem_addr/mem_wdata/mem_wflag/mem_we/mem_re toward the memory controller.
- Waits for mem_ready, then returns aligned, sign/zero-extended load data or a store completion.
- Rejects illegal or misaligned accesses and times out on an unresponsive controller, reporting both as an error response.

Parameters:
TIMEOUT_CYCLES, 16, ACCESS-state cycles without mem_ready before abort (min 2)
ALIGN_CHECK, 1, 1 = reject misaligned halfword/word accesses; 0 = pass all addresses through

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready at rising edge
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data, low-order bytes significant
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  valid with resp_valid; illegal funct3, misaligned, or timeout
resp_rdata  output  32  extended load data; 0 for stores and errors
mem_addr  output  32  to memory controller
mem_wdata  output  32  to memory controller
mem_wflag  output  3  store funct3 to memory controller
mem_we  output  1  write strobe
mem_re  output  1  read strobe
mem_rdata  input  32  byte 0 = byte at mem_addr, byte 1 = mem_addr+1, etc.
mem_ready  input  1  controller completion, updated on falling edge

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_re=0.
  - mem_addr=0, mem_wdata=0, mem_wflag=3'b010.
  - Timeout counter=0.
  - Reset mid-ACCESS drops the strobes at once; no response is issued.
- FSM states: IDLE, ACCESS, RESP. req_ready=1 only in IDLE.
- IDLE, on accept:
  - Legal store funct3: 000, 001, 010.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Misaligned (only when ALIGN_CHECK=1): halfword with addr[0]=1, word with addr[1:0]!=0.
  - Illegal or misaligned: go to RESP with resp_err=1 and resp_rdata=0; no strobe is ever raised.
  - Otherwise: register mem_addr=req_addr and mem_wdata=req_wdata unmodified.
  - Store: mem_wflag=req_funct3, mem_we=1. Load: mem_wflag=3'b010, mem_re=1.
  - Clear counter and go to ACCESS.
- ACCESS:
  - mem_addr, mem_wdata, mem_wflag and the strobe are held stable.
  - mem_ready=1 sampled: drop the strobe, latch the extended result, go to RESP with resp_err=0.
  - Else, counter==TIMEOUT_CYCLES-1: drop the strobe, resp_err=1, resp_rdata=0, go to RESP.
  - Else: counter+1.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_* are held until the next response.
- Load extension uses mem_rdata low bits only; no lane shifting:
  - LB = {{24{d[7]}}, d[7:0]}.
  - LBU = {24'b0, d[7:0]}.
  - LH = {{16{d[15]}}, d[15:0]}.
  - LHU = {16'b0, d[15:0]}.
  - LW = d.
- Latency and throughput:
  - Legal request accepted at edge N; controller answers at falling edge N.
  - mem_ready is seen at edge N+1; resp_valid is high from N+1 to N+2.
  - Next accept is at edge N+3 at the earliest.
  - The idle gap guarantees the previous request's mem_ready has fallen before a new strobe.
- mem_ready sampled in IDLE or RESP is ignored.
- mem_ready in the same cycle as the timeout compare takes priority: normal completion.
- Strobes are never both high.
- mem_addr/mem_wdata/mem_wflag hold their last value outside ACCESS.

Test Plan:
- SW addr 0x2000 data 0xDEADBEEF against a controller model with ready on the following falling edge:
  - mem_we high for exactly 1 cycle, mem_wflag=010.
  - resp_valid 1 cycle after accept, resp_err=0.
  - Then LW 0x2000 returns resp_rdata=0xDEADBEEF.
- SB addr 0x2001 data 0x80, then:
  - LB 0x2001 -> 0xFFFFFF80.
  - LBU 0x2001 -> 0x00000080.
  - LH 0x2000 with memory bytes {0x80,0xEF} -> 0xFFFF80EF.
  - LHU of the same -> 0x000080EF.
- ALIGN_CHECK=1:
  - LW 0x2002 -> resp_err=1, resp_rdata=0, mem_re never asserted.
  - SH 0x2001 -> resp_err=1, mem_we never asserted.
  - Load funct3=011 -> resp_err=1.
- mem_ready tied 0, TIMEOUT_CYCLES=16, LW 0x2004:
  - mem_re high for exactly 16 cycles, then drops.
  - resp_valid with resp_err=1 on the following cycle.
  - req_ready returns the cycle after that.
- Back-to-back: req_valid held high with 4 legal loads -> accepts spaced exactly 3 cycles, 4 resp_valid pulses, no strobe asserted while mem_ready is still high from the prior access.
- Assert rst_n=0 mid-ACCESS of an SW -> mem_we falls asynchronously, no resp_valid, req_ready=1 after release, next LW completes normally.
